// File: rtl/axi_instr_arbiter.sv
// Two-master round-robin arbiter for a shared instruction-fetch AXI read slave.
// One transaction in flight; a silent slave is answered with ERR_DATA after TIMEOUT cycles.
module axi_instr_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic        owner,
    output logic        busy,
    output logic        timeout_err
);
    typedef enum logic [1:0] {StIdle, StArIssue, StRWait, StErrResp} state_t;

    localparam logic [15:0] TimerLast = 16'(TIMEOUT - 1);

    state_t      r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_last_grant, w_last_grant_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [15:0] r_timer, w_timer_nxt;
    logic        w_gnt0, w_gnt1, w_own_rready, w_timeout_hit, w_rvalid;
    logic [31:0] w_rdata;

    // On a tie the master that was not granted last time wins.
    assign w_gnt0        = m0_arvalid & (~m1_arvalid | r_last_grant);
    assign w_gnt1        = m1_arvalid & (~m0_arvalid | ~r_last_grant);
    assign w_own_rready  = r_owner ? m1_rready : m0_rready;
    // Fires in the silent R_WAIT cycle whose increment brings the timer to TIMEOUT.
    assign w_timeout_hit = (r_state == StRWait) & ~s_rvalid & (r_timer == TimerLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= '0;
            r_timer      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_addr       <= w_addr_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    always_comb begin : next_state
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_grant_nxt = r_last_grant;
        w_addr_nxt       = r_addr;
        w_timer_nxt      = r_timer;
        unique case (r_state)
            StIdle: begin
                if (w_gnt0 | w_gnt1) begin
                    w_owner_nxt = w_gnt1;
                    w_addr_nxt  = w_gnt1 ? m1_araddr : m0_araddr;
                    w_state_nxt = StArIssue;
                end
            end
            StArIssue: begin
                if (s_arready) begin
                    w_state_nxt = StRWait;
                    w_timer_nxt = '0;
                end
            end
            StRWait: begin
                if (s_rvalid) begin
                    if (w_own_rready) begin
                        w_last_grant_nxt = r_owner;
                        w_state_nxt      = StIdle;
                    end
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                    if (w_timeout_hit) w_state_nxt = StErrResp;
                end
            end
            StErrResp: begin
                if (w_own_rready) begin
                    w_last_grant_nxt = r_owner;
                    w_state_nxt      = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin : outputs
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        w_rvalid   = 1'b0;
        w_rdata    = '0;
        unique case (r_state)
            StIdle: begin
                // Reset holds the FSM in IDLE, so gate the combinational grant explicitly.
                m0_arready = rst_n & w_gnt0;
                m1_arready = rst_n & w_gnt1;
            end
            StArIssue: s_arvalid = 1'b1;
            StRWait: begin
                w_rvalid = s_rvalid;
                w_rdata  = s_rdata;
                s_rready = w_own_rready;
            end
            StErrResp: begin
                w_rvalid = 1'b1;
                w_rdata  = ERR_DATA;
            end
            default: ;
        endcase
        m0_rvalid = w_rvalid & ~r_owner;
        m1_rvalid = w_rvalid & r_owner;
        m0_rdata  = r_owner ? 32'h0 : w_rdata;
        m1_rdata  = r_owner ? w_rdata : 32'h0;
    end

    assign s_araddr    = r_addr;
    assign owner       = r_owner;
    assign busy        = (r_state != StIdle);
    assign timeout_err = w_timeout_hit;

endmodule

// File: tb/tb_axi_instr_arbiter.sv
// Bench for axi_instr_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_axi_instr_arbiter;
    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk, rst_n;
    logic [31:0] m0_araddr, m1_araddr, s_rdata, s_araddr, m0_rdata, m1_rdata;
    logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready, s_arready, s_rvalid;
    logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid, s_arvalid, s_rready;
    logic        owner, busy, timeout_err;

    int n_vec = 0;
    int n_err = 0;

    axi_instr_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .owner(owner), .busy(busy), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 address out, 2 waiting for data, 3 error reply.
    int          m_phase = 0;
    int          m_wait  = 0;
    logic        m_owner = 1'b0;
    logic        m_last  = 1'b1;
    logic [31:0] m_addr  = '0;
    int          exp_win;
    logic        own_rr;

    function automatic int winner(input logic r0, input logic r1, input logic last);
        if (r0 && r1) return last ? 0 : 1;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    always_comb exp_win = winner(m0_arvalid, m1_arvalid, m_last);
    always_comb own_rr = m_owner ? m1_rready : m0_rready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_wait <= 0; m_owner <= 1'b0; m_last <= 1'b1; m_addr <= '0;
        end else begin
            case (m_phase)
                0: if (exp_win >= 0) begin
                    m_owner <= (exp_win == 1);
                    m_addr  <= (exp_win == 1) ? m1_araddr : m0_araddr;
                    m_phase <= 1;
                end
                1: if (s_arready) begin m_phase <= 2; m_wait <= 0; end
                2: if (s_rvalid && own_rr) begin
                    m_last <= m_owner; m_phase <= 0;
                end else if (!s_rvalid) begin
                    m_wait <= m_wait + 1;
                    if (m_wait + 1 == int'(TO)) m_phase <= 3;
                end
                3: if (own_rr) begin m_last <= m_owner; m_phase <= 0; end
                default: m_phase <= 0;
            endcase
        end
    end

    logic        e_rv0, e_rv1, e_srr;
    logic [31:0] e_rd0, e_rd1;
    always_comb begin
        e_rv0 = 1'b0; e_rv1 = 1'b0; e_srr = 1'b0; e_rd0 = '0; e_rd1 = '0;
        if (m_phase == 2) begin
            e_srr = own_rr;
            if (m_owner) begin e_rv1 = s_rvalid; e_rd1 = s_rdata; end
            else begin e_rv0 = s_rvalid; e_rd0 = s_rdata; end
        end else if (m_phase == 3) begin
            if (m_owner) begin e_rv1 = 1'b1; e_rd1 = ERR; end
            else begin e_rv0 = 1'b1; e_rd0 = ERR; end
        end
    end

    always @(negedge clk) begin
        chk1("m0_arready", m0_arready, rst_n && m_phase == 0 && exp_win == 0);
        chk1("m1_arready", m1_arready, rst_n && m_phase == 0 && exp_win == 1);
        chk1("s_arvalid", s_arvalid, m_phase == 1);
        if (m_phase == 1) chk32("s_araddr", s_araddr, m_addr);
        chk1("m0_rvalid", m0_rvalid, e_rv0);
        chk32("m0_rdata", m0_rdata, e_rd0);
        chk1("m1_rvalid", m1_rvalid, e_rv1);
        chk32("m1_rdata", m1_rdata, e_rd1);
        chk1("s_rready", s_rready, e_srr);
        chk1("busy", busy, m_phase != 0);
        if (m_phase != 0) chk1("owner", owner, m_owner);
        chk1("timeout_err", timeout_err, m_phase == 2 && !s_rvalid && m_wait == int'(TO) - 1);
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 50) begin cyc(1); k++; end
        chk1(name, busy, 1'b0);
    endtask

    int order[4];
    int exp_order[4] = '{0, 1, 0, 1};
    int ngr, bp, tcnt;

    initial begin
        rst_n = 1'b1;
        m0_araddr = '0; m1_araddr = '0; s_rdata = '0;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_rvalid = 1'b1;
        m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b0;
        #1 rst_n = 1'b0;
        cyc(2);
        #1;
        chk1("rst_m0_arready", m0_arready, 1'b0);
        chk1("rst_m1_arready", m1_arready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_m0_rdata", m0_rdata, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1; m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_rvalid = 1'b0;
        cyc(1);

        // Continuous tie: grants alternate starting with m0.
        m0_araddr = 32'h0000_1000; m1_araddr = 32'h0000_2000;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_arready = 1'b1;
        s_rvalid = 1'b1; s_rdata = 32'h0000_0A0A;
        ngr = 0;
        for (int i = 0; i < 40 && ngr < 4; i++) begin
            #1;
            if (m0_arready) begin order[ngr] = 0; ngr++; end
            else if (m1_arready) begin order[ngr] = 1; ngr++; end
            @(posedge clk); #2;
        end
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        chk32("tie_grants", ngr, 4);
        for (int k = 0; k < 4; k++) chk32("tie_order", order[k], exp_order[k]);
        wait_idle("tie_drain");
        s_rvalid = 1'b0; s_arready = 1'b0;
        cyc(1);

        // Single fetch, slave AR accepted after 2 cycles.
        m0_araddr = 32'h0000_0100; m0_arvalid = 1'b1;
        #1;
        chk1("fetch_arready", m0_arready, 1'b1);
        chk1("fetch_no_early_sar", s_arvalid, 1'b0);
        cyc(1); m0_arvalid = 1'b0;
        cyc(2);
        #1;
        chk1("fetch_sarvalid", s_arvalid, 1'b1);
        chk32("fetch_saraddr", s_araddr, 32'h0000_0100);
        s_arready = 1'b1;
        cyc(1); s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0013;
        #1;
        chk1("fetch_m0_rvalid", m0_rvalid, 1'b1);
        chk32("fetch_m0_rdata", m0_rdata, 32'h0000_0013);
        chk1("fetch_m1_rvalid", m1_rvalid, 1'b0);
        cyc(1); s_rvalid = 1'b0;
        #1 chk1("fetch_done", busy, 1'b0);

        // Request withdrawn before the edge starts nothing.
        m1_arvalid = 1'b1;
        #3 m1_arvalid = 1'b0;
        cyc(1);
        chk1("withdraw_idle", busy, 1'b0);

        // Backpressure from m1 for 3 cycles.
        m1_araddr = 32'h0000_0200; m1_arvalid = 1'b1; m1_rready = 1'b0; s_arready = 1'b1;
        cyc(1); m1_arvalid = 1'b0;
        cyc(1); s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_0001;
        bp = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (!s_rready && m1_rvalid && m1_rdata == 32'hCAFE_0001) bp++;
            cyc(1);
        end
        chk32("bp_stall_cycles", bp, 3);
        m1_rready = 1'b1;
        #1 chk1("bp_release", s_rready, 1'b1);
        cyc(1); s_rvalid = 1'b0;
        #1 chk1("bp_done", busy, 1'b0);
        cyc(1);

        // Slave AR stall for 5 cycles while m1 also requests.
        m0_araddr = 32'h2000_0040; m0_arvalid = 1'b1; m0_rready = 1'b1;
        cyc(1);
        m0_arvalid = 1'b0; m0_araddr = 32'hFFFF_FFFF;
        m1_arvalid = 1'b1; m1_araddr = 32'h3000_0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("stall_sarvalid", s_arvalid, 1'b1);
            chk32("stall_saraddr", s_araddr, 32'h2000_0040);
            chk1("stall_m1_arready", m1_arready, 1'b0);
            cyc(1);
        end
        m1_arvalid = 1'b0; s_arready = 1'b1;
        cyc(1); s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0055;
        cyc(1); s_rvalid = 1'b0;
        wait_idle("stall_done");

        // Timeout: slave stays silent after the AR handshake.
        m0_araddr = 32'h0000_0300; m0_arvalid = 1'b1; m0_rready = 1'b0; s_arready = 1'b1;
        cyc(1); m0_arvalid = 1'b0;
        cyc(1); s_arready = 1'b0;
        tcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (timeout_err) begin tcnt = i; break; end
            cyc(1);
        end
        chk32("timeout_cycles", tcnt, 8);
        cyc(1);
        s_rvalid = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        chk1("err_rvalid", m0_rvalid, 1'b1);
        chk32("err_rdata", m0_rdata, ERR);
        chk1("err_pulse_once", timeout_err, 1'b0);
        chk1("err_no_srready", s_rready, 1'b0);
        cyc(1); m0_rready = 1'b1;
        cyc(1); m0_rready = 1'b0; s_rvalid = 1'b0;

        // Next request is granted, then reset lands mid R_WAIT.
        m1_araddr = 32'h0000_4000; m1_arvalid = 1'b1;
        #1 chk1("post_err_grant", m1_arready, 1'b1);
        cyc(1); m1_arvalid = 1'b0; s_arready = 1'b1;
        cyc(1); s_arready = 1'b0;
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_m1_rvalid", m1_rvalid, 1'b0);
        chk1("rst_mid_srready", s_rready, 1'b0);
        cyc(1);
        rst_n = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h0BAD_0BAD;
        cyc(1);
        s_rvalid = 1'b0;
        m0_araddr = 32'h0000_5000; m1_araddr = 32'h0000_6000;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
        #1;
        chk1("rst_tie_m0", m0_arready, 1'b1);
        chk1("rst_tie_m1", m1_arready, 1'b0);
        cyc(1); m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_arready = 1'b1;
        cyc(1); s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h0000_0077; m0_rready = 1'b1;
        cyc(1); s_rvalid = 1'b0;
        wait_idle("final_idle");
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end by %0t", $time);
        $fatal(1);
    end

endmodule
